// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, signed/unsigned.
// Signed operands are reduced to magnitudes up front and the sign is reapplied on the final add.
module seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);
  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [2*N:0]     acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [2*N-1:0]   p_q, p_d;

  logic             a_neg, b_neg, last;
  logic [N-1:0]     a_mag, b_mag;

  // -2^(N-1) has magnitude 2^(N-1), which still fits N unsigned bits
  assign a_neg = signed_mode & a[N-1];
  assign b_neg = signed_mode & b[N-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign last  = (cnt_q == CW'(N-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    p_d      = p_q;
    if (state_q == IDLE && in_valid) begin
      mcand_d  = {{N{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
      cnt_d    = '0;
      neg_d    = a_neg ^ b_neg;
    end else if (state_q == CALC) begin
      acc_d    = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last) p_d = neg_q ? -acc_d[2*N-1:0] : acc_d[2*N-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
    end
  end

  assign p = p_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboarded bench: directed N=8 vectors, stall/reset/toggle cases, and random
// transactions on N=2,5,16 instances against an arithmetic reference.
module tb_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, sm, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] p;
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, acc_cyc = 0;
  bit          hs_pend = 0, ov_seen = 0;
  bit          gdone [3];
  longint      q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_multiplier #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(sm), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .busy(busy)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint ref_mul(longint x, longint y, bit s, int w);
    longint sx = x, sy = y;
    longint m = (longint'(1) << (2*w)) - 1;
    if (s && x[w-1]) sx = x - (longint'(1) << w);
    if (s && y[w-1]) sy = y - (longint'(1) << w);
    return (sx * sy) & m;
  endfunction

  // N=8 monitor: push on accept, pop on output handshake, check latency and ready
  always @(negedge clk) if (rst_n) begin
    if (hs_pend) begin
      chk("ready_after_hs", in_ready, 1);
      chk("valid_after_hs", out_valid, 0);
      hs_pend = 0;
    end
    if (out_valid && !ov_seen) begin
      ov_seen = 1;
      chk("latency", cyc - acc_cyc, 9);
    end
    if (in_valid && in_ready) begin
      chk("no_overlap", q.size(), 0);
      q.push_back(ref_mul(a, b, sm, 8));
      acc_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else chk("p", p, q.pop_front());
      hs_pend = 1;
      ov_seen = 0;
    end
  end

  task automatic wait_accept();
    int n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic op(input logic [7:0] ta, input logic [7:0] tb_, input bit ts, input bit toggle);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1; a = ta; b = tb_; sm = ts;
    wait_accept();
    if (toggle) begin
      while (!out_valid && n < 50) begin
        a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
        @(posedge clk); #1; n++;
      end
    end else begin
      a = 8'($urandom); b = 8'($urandom);
    end
    in_valid = 0;
    wait_drain();
  endtask

  task automatic op_exp(input logic [7:0] ta, input logic [7:0] tb_, input bit ts, input longint e, input string tag);
    op(ta, tb_, ts, 0);
    chk(tag, p, e);
  endtask

  initial begin
    longint pk;
    int     n;
    rst_n = 0; in_valid = 0; a = 0; b = 0; sm = 0; out_ready = 1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p", p, 0);
    @(posedge clk); #1; rst_n = 1;

    op_exp(8'hFF, 8'hFF, 0, 64'hFE01, "uu_max");
    op_exp(8'h80, 8'h80, 1, 64'h4000, "ss_min_min");
    op_exp(8'hFF, 8'h7F, 1, 64'hFF81, "ss_m1_127");
    op_exp(8'hFF, 8'h7F, 0, 64'h7E81, "uu_255_127");
    op_exp(8'h00, 8'h5A, 0, 64'h0000, "zero_a_u");
    op_exp(8'h00, 8'hA5, 1, 64'h0000, "zero_a_s");
    op_exp(8'hA5, 8'h00, 1, 64'h0000, "zero_b_s");
    op_exp(8'h80, 8'hFF, 1, 64'h0080, "ss_min_m1");

    // consumer stall: output and p must hold while out_ready is low
    @(posedge clk); #1;
    out_ready = 0; in_valid = 1; a = 8'h3C; b = 8'hC3; sm = 1;
    wait_accept();
    in_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    pk = p;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_p", p, pk);
      chk("stall_in_ready", in_ready, 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1; out_ready = 1;
    wait_drain();

    op(8'h5D, 8'hE2, 1, 1);
    op(8'hC4, 8'h19, 0, 1);

    // async reset mid-CALC aborts, then accept on the first edge after release
    @(posedge clk); #1;
    in_valid = 1; a = 8'h37; b = 8'h5B; sm = 0;
    wait_accept();
    in_valid = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_p", p, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    q.delete(); hs_pend = 0; ov_seen = 0;
    @(negedge clk);
    in_valid = 1; a = 8'h9C; b = 8'h03; sm = 1;
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1; in_valid = 0;
    chk("accept_after_rst", busy, 1);
    wait_drain();
    chk("post_rst_p", p, 64'hFED4);

    for (int i = 0; i < 30; i++) op(8'($urandom), 8'($urandom), 1'($urandom), 0);

    n = 0;
    while (!(gdone[0] && gdone[1] && gdone[2]) && n < 20000) begin @(negedge clk); n++; end
    if (!(gdone[0] && gdone[1] && gdone[2])) chk("gen_timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int W = (g == 0) ? 2 : (g == 1) ? 5 : 16;
    logic           r_rst_n, r_in_valid, r_in_ready, r_sm, r_out_valid, r_out_ready, r_busy;
    logic [W-1:0]   r_a, r_b;
    logic [2*W-1:0] r_p;
    longint         sq [$];

    seq_multiplier #(.N(W)) u_dut (
      .clk(clk), .rst_n(r_rst_n), .in_valid(r_in_valid), .in_ready(r_in_ready),
      .a(r_a), .b(r_b), .signed_mode(r_sm), .out_valid(r_out_valid),
      .out_ready(r_out_ready), .p(r_p), .busy(r_busy)
    );

    initial begin
      int n;
      r_rst_n = 0; r_in_valid = 0; r_a = '0; r_b = '0; r_sm = 0; r_out_ready = 1;
      repeat (2) @(posedge clk);
      #1 r_rst_n = 1;
      for (int i = 0; i < 25; i++) begin
        r_in_valid = 1;
        if (i == 0)      begin r_a = '0; r_a[W-1] = 1'b1; r_b = r_a; r_sm = 1; end
        else if (i == 1) begin r_a = '1; r_b = '1; r_sm = 0; end
        else             begin r_a = W'($urandom); r_b = W'($urandom); r_sm = 1'($urandom); end
        n = 0;
        do begin @(negedge clk); n++; end while (!r_in_ready && n < 50);
        sq.push_back(ref_mul(r_a, r_b, r_sm, W));
        @(posedge clk); #1;
        r_in_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!r_out_valid && n < 50);
        if (!r_out_valid) chk("gen_out_timeout", W, 0);
        chk("gen_p", r_p, sq.pop_front());
        @(posedge clk); #1;
      end
      gdone[g] = 1;
    end
  end
endmodule
